// File: rtl/eight_bit_divider_sequential_pkg.sv
// Shared computation-datapath constants: default operand width and divider FSM state encoding.
package eight_bit_divider_sequential_pkg;

    // Operand width shared with the 8-bit structural multiplier.
    localparam int DIV_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/eight_bit_divider_sequential_if.sv
// Start/busy/done handshake plus operand and result buses between the controller and the divider.
interface eight_bit_divider_sequential_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/eight_bit_divider_sequential_step.sv
// One combinational restoring-division step, with the trial subtraction done on a ripple-carry adder.
module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    logic [WIDTH:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar g = 0; g < WIDTH; g++) begin : g_fa
        assign o_sum[g]       = i_a[g] ^ i_b[g] ^ w_carry[g];
        assign w_carry[g + 1] = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cout = w_carry[WIDTH];
endmodule

module divider_restore_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_diff_lo;
    logic             w_cout;
    logic             w_trial_msb;

    assign w_shifted = {i_rem, i_bit};

    ripple_carry_adder #(.WIDTH(WIDTH)) u_sub (
        .i_a    (w_shifted[WIDTH-1:0]),
        .i_b    (~i_divisor),
        .i_cin  (1'b1),
        .o_sum  (w_diff_lo),
        .o_cout (w_cout)
    );

    // Top trial bit: shifted MSB plus the inverted zero-extension bit (1) plus the low carry.
    assign w_trial_msb = ~(w_shifted[WIDTH] ^ w_cout);
    assign o_qbit      = ~w_trial_msb;

    // A kept or restored remainder is always below the divisor, so its top bit is zero.
    assign o_rem = o_qbit ? w_diff_lo : w_shifted[WIDTH-1:0];
endmodule

// File: rtl/eight_bit_divider_sequential.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define EIGHT_BIT_DIVIDER_EARLY_ZERO_EN to complete zero-divisor requests without iterating.
module eight_bit_divider_sequential
    import eight_bit_divider_sequential_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    eight_bit_divider_sequential_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_qreg;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_zero;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_qbit;

    // A new request is taken in IDLE and also in the DONE cycle for back-to-back operation.
    assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_count == CNT_W'(1));

    divider_restore_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_qreg[WIDTH-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_rem       <= '0;
            r_qreg      <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else if (w_accept) begin
            r_divisor <= bus.divisor;
            r_qreg    <= bus.dividend;
            r_rem     <= '0;
            r_count   <= CNT_W'(WIDTH);
`ifdef EIGHT_BIT_DIVIDER_EARLY_ZERO_EN
            if (bus.divisor == '0) begin
                r_state     <= ST_DONE;
                r_quotient  <= '1;
                r_remainder <= bus.dividend;
                r_div_zero  <= 1'b1;
            end else begin
                r_state <= ST_RUN;
            end
`else
            r_state <= ST_RUN;
`endif
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_rem   <= w_step_rem;
                    r_qreg  <= {r_qreg[WIDTH-2:0], w_step_qbit};
                    r_count <= r_count - CNT_W'(1);
                    if (w_last) begin
                        r_state     <= ST_DONE;
                        r_quotient  <= {r_qreg[WIDTH-2:0], w_step_qbit};
                        r_remainder <= w_step_rem;
                        r_div_zero  <= (r_divisor == '0);
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = (r_state == ST_RUN);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.div_zero  = r_div_zero;
endmodule

// File: tb/tb_eight_bit_divider_sequential.sv
// Self-checking bench: directed cases with literal expectations plus randomized traffic vs. an arithmetic model.
module tb_eight_bit_divider_sequential;
    localparam int W = 8;
`ifdef EIGHT_BIT_DIVIDER_EARLY_ZERO_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    eight_bit_divider_sequential_if #(.WIDTH(W)) bus ();

    eight_bit_divider_sequential #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Reference model: results from plain / and %, timing from the handshake rules.
    logic         m_busy, m_done, m_dz, p_dz;
    logic [W-1:0] m_q, m_r, p_q, p_r;
    int           m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
            m_q <= '0; m_r <= '0; m_left <= 0;
            p_q <= '0; p_r <= '0; p_dz <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1;
                    m_q <= p_q; m_r <= p_r; m_dz <= p_dz;
                end
            end else if (bus.start) begin
                if (bus.divisor == 0) begin
                    p_q <= 8'hFF; p_r <= bus.dividend; p_dz <= 1'b1;
                end else begin
                    p_q <= bus.dividend / bus.divisor;
                    p_r <= bus.dividend % bus.divisor;
                    p_dz <= 1'b0;
                end
                if (EARLY && bus.divisor == 0) begin
                    m_done <= 1'b1; m_q <= 8'hFF; m_r <= bus.dividend; m_dz <= 1'b1;
                end else begin
                    m_busy <= 1'b1; m_left <= W;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", bus.busy, m_busy);
            check("cyc_done", bus.done, m_done);
            check("cyc_quotient", bus.quotient, m_q);
            check("cyc_remainder", bus.remainder, m_r);
            check("cyc_div_zero", bus.div_zero, m_dz);
        end
    end

    // Start pulsed for one cycle; start edge is cycle 0, done cycle is counted from there.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int eq, input int er,
                          input int edz, input int elat, input string name);
        int lat;
        int nbusy;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        nbusy = 0;
        while (!bus.done && lat < 30) begin
            if (bus.busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, elat);
        check({name, "_busy_cycles"}, nbusy, elat - 1);
        check({name, "_quotient"}, bus.quotient, eq);
        check({name, "_remainder"}, bus.remainder, er);
        check({name, "_div_zero"}, bus.div_zero, edz);
    endtask

    initial begin
        int lat;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_div_zero", bus.div_zero, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        run_op(8'd200, 8'd7, 28, 4, 0, 9, "d200_7");
        run_op(8'd255, 8'd255, 1, 0, 0, 9, "d255_255");
        run_op(8'd0, 8'd3, 0, 0, 0, 9, "d0_3");
        run_op(8'd255, 8'd1, 255, 0, 0, 9, "d255_1");
        run_op(8'd5, 8'd0, 255, 5, 1, EARLY ? 1 : 9, "d5_0");
        run_op(8'd9, 8'd200, 0, 9, 0, 9, "d9_200");

        // Start pulse with new operands in the middle of a run is ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 5;
        while (!bus.done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("ignore_latency", lat, 9);
        check("ignore_quotient", bus.quotient, 11);
        check("ignore_remainder", bus.remainder, 1);

        // Asynchronous reset in cycle 5 of 200/7.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_quotient", bus.quotient, 0);
        check("midrst_remainder", bus.remainder, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'd17, 8'd4, 4, 1, 0, 9, "after_rst_17_4");

        // Back-to-back: start held across the DONE cycle of 200/7 with 81/9.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd81; bus.divisor = 8'd9;
        @(negedge clk);
        check("b2b_first_done", bus.done, 1);
        check("b2b_first_quotient", bus.quotient, 28);
        check("b2b_first_remainder", bus.remainder, 4);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 10;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_second_latency", lat, 18);
        check("b2b_second_quotient", bus.quotient, 9);
        check("b2b_second_remainder", bus.remainder, 0);

        // Randomized traffic, including starts while busy, zero divisors and rare resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.start    = ($urandom_range(0, 3) == 0);
            bus.dividend = W'($urandom);
            bus.divisor  = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
